// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl: frames a serial complex sample stream into a 4-point FFT core.
// It collects four samples and holds them on the core inputs.
// It runs the core for CORE_LAT enabled cycles and then captures the four bins.
// The bins stream out serially under valid/ready backpressure.
// Optional build macro FFT4_SCALE_EN pre-scales each accepted sample by >>>2 so the
// core cannot overflow; without it samples pass through unmodified.
module fft4_frame_ctrl #(
   parameter int unsigned CORE_LAT = 2,
   parameter int unsigned FCW      = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [15:0]    s_re,
   input  logic [15:0]    s_im,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [15:0]    m_re,
   output logic [15:0]    m_im,
   output logic           m_last,
   output logic           core_ce,
   output logic [63:0]    core_xre,
   output logic [63:0]    core_xim,
   input  logic [63:0]    core_yre,
   input  logic [63:0]    core_yim,
   output logic           busy,
   output logic [FCW-1:0] frame_cnt
);

   localparam int unsigned CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
   localparam logic [CW-1:0] LAT_LAST = CW'(CORE_LAT - 1);

   typedef enum logic [1:0] {COLLECT, RUN, CAP} state_t;

   state_t        state;
   logic [1:0]    in_idx;
   logic [1:0]    out_idx;
   logic [CW-1:0] lat_cnt;
   logic          out_full;
   logic [15:0]   buf_re [4];
   logic [15:0]   buf_im [4];
   logic [15:0]   wr_re;
   logic [15:0]   wr_im;
   logic          m_fire;
   logic          last_beat;
   logic          capture;

`ifdef FFT4_SCALE_EN
   assign wr_re = 16'($signed(s_re) >>> 2);
   assign wr_im = 16'($signed(s_im) >>> 2);
`else
   assign wr_re = s_re;
   assign wr_im = s_im;
`endif

   assign s_ready   = (state == COLLECT);
   assign m_valid   = out_full;
   assign m_re      = buf_re[out_idx];
   assign m_im      = buf_im[out_idx];
   assign m_last    = out_full && (out_idx == 2'd3);
   assign m_fire    = out_full && m_ready;
   assign last_beat = m_fire && (out_idx == 2'd3);
   // Capture may reuse the buffer on the very beat that empties it, so there is no bubble.
   assign capture   = (state == CAP) && (!out_full || last_beat);
   assign busy      = (state != COLLECT) || out_full;

   // Input FSM: collect four lanes, run the core, then wait for the out buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= COLLECT;
         in_idx   <= 2'd0;
         lat_cnt  <= '0;
         core_ce  <= 1'b0;
         core_xre <= '0;
         core_xim <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (s_valid) begin
                  core_xre[16*in_idx +: 16] <= wr_re;
                  core_xim[16*in_idx +: 16] <= wr_im;
                  in_idx <= in_idx + 2'd1;
                  if (in_idx == 2'd3) begin
                     state   <= RUN;
                     core_ce <= 1'b1;
                     lat_cnt <= '0;
                  end
               end
            end
            RUN: begin
               if (lat_cnt == LAT_LAST) begin
                  state   <= CAP;
                  core_ce <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt + CW'(1);
               end
            end
            CAP: begin
               if (capture) begin
                  state <= COLLECT;
               end
            end
            default: begin
               state   <= COLLECT;
               core_ce <= 1'b0;
            end
         endcase
      end
   end

   // Output buffer: capture bins, serialise them, count drained frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_full  <= 1'b0;
         out_idx   <= 2'd0;
         frame_cnt <= '0;
         for (int k = 0; k < 4; k++) begin
            buf_re[k] <= 16'd0;
            buf_im[k] <= 16'd0;
         end
      end else begin
         if (capture) begin
            out_full <= 1'b1;
            for (int k = 0; k < 4; k++) begin
               buf_re[k] <= core_yre[16*k +: 16];
               buf_im[k] <= core_yim[16*k +: 16];
            end
         end else if (last_beat) begin
            out_full <= 1'b0;
         end
         if (m_fire) begin
            out_idx <= out_idx + 2'd1;
            if (out_idx == 2'd3) begin
               frame_cnt <= frame_cnt + FCW'(1);
            end
         end
      end
   end

endmodule

// File: doc/fft4_frame_ctrl.md
Name: fft4_frame_ctrl

Overview:
- Sequences a 4-point complex FFT core (two radix-2 pairs plus a combining stage, 16-bit signed I/Q, clock-enabled pipeline) from a serial sample stream.
- Collects 4 serial samples, presents them in parallel to the core, holds them and pulses core_ce for the core's latency, then captures the 4 bins.
- Streams the bins out serially with valid/ready backpressure.
- Collection of frame n+1 overlaps draining of frame n.

Parameters:
- CORE_LAT, 2: cycles core_ce is held high per frame before capture (≥1).
- FCW, 16: width of frame_cnt.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_re  in  16  input real, signed
- s_im  in  16  input imag, signed
- m_valid  out  1  output bin valid
- m_ready  in  1  output bin ready
- m_re  out  16  output bin real, signed
- m_im  out  16  output bin imag, signed
- m_last  out  1  high on bin 3 of a frame
- core_ce  out  1  core clock enable
- core_xre  out  64  core real inputs; lane k = [16k+15:16k] = sample k
- core_xim  out  64  core imag inputs, same packing
- core_yre  in  64  core real outputs; lane k = bin k
- core_yim  in  64  core imag outputs
- busy  out  1  input FSM not in COLLECT, or out buffer full
- frame_cnt  out  FCW  frames fully drained, wraps modulo 2^FCW

Behaviour:
- Reset (async assert, sync deassert by system):
  - state=COLLECT; in_idx=0; out_full=0; out_idx=0.
  - core_xre/core_xim=0, core_ce=0, frame_cnt=0, m_re/m_im=0.
- Input FSM states: COLLECT, RUN, CAP.
- COLLECT:
  - s_ready=1 (combinational on state), all other states s_ready=0.
  - On s_valid&s_ready: write lane in_idx, in_idx++.
  - Beat with in_idx=3 → in_idx=0, next state RUN.
- RUN:
  - core_ce=1; core_xre/core_xim held stable.
  - Counter runs CORE_LAT cycles, then → CAP.
- CAP:
  - core_ce=0; inputs still held.
  - Capture all 4 lanes of core_yre/core_yim into out buffer, set out_full=1, → COLLECT.
  - Capture occurs when out_full=0, or in the same cycle the final out beat handshakes (out_idx=3 & m_valid & m_ready). Otherwise stall in CAP.
- Latency: last input beat accepted at edge t → core_ce high cycles t+1..t+CORE_LAT → capture edge t+CORE_LAT+1 → m_valid high from the following cycle if no stall. With CORE_LAT=2, m_valid rises 4 cycles after the last input beat.
- Output side:
  - m_valid=out_full.
  - m_re/m_im = out lane out_idx (combinational mux from buffer).
  - m_last = out_full & (out_idx==3).
  - On m_valid&m_ready: out_idx++. On the last beat: out_idx=0, out_full=0 unless a capture happens the same cycle (capture wins, out_full stays 1), frame_cnt++.
- m_re/m_im/m_valid must stay stable while m_valid & !m_ready.
- Arithmetic: no arithmetic in the datapath; bins are passed unchanged. Core overflow is not detected or corrected.
- Simultaneous events:
  - Last drain beat + CAP capture in the same cycle: no bubble.
  - With m_ready=1 continuously and no s_valid gaps: 4 outputs per 4+CORE_LAT+1 cycles.
- Reset mid-frame: partial input frame and undrained output frame are discarded; frame_cnt=0.
- frame_cnt wrap: 2^FCW−1 → 0.

Optional Feature:
- FFT4_SCALE_EN.
- Defined: each accepted sample is arithmetic-shifted right by 2 (sign-extended, truncation toward −inf) before being written to core_xre/core_xim. This guarantees no core overflow for any input.
- Undefined: samples are written unmodified.

Test Plan:
- Impulse: s = (1000,0),(0,0),(0,0),(0,0), m_ready=1 → four bins (1000,0), m_last on the 4th; m_valid rises 4 cycles after the 4th input beat (CORE_LAT=2). With FFT4_SCALE_EN: bins (250,0).
- Shifted impulse: s = 0,(1000,0),0,0 → bins (1000,0),(0,−1000),(−1000,0),(0,1000).
- DC: four samples (100,−50) → bins (400,−200),(0,0),(0,0),(0,0); frame_cnt=1 after the last beat.
- Backpressure: m_ready low 10 cycles on bin 1 while the next frame is fully collected → m_re/m_im stable; FSM stalls in CAP with s_ready=0. Releasing m_ready drains bins 1–3, and the next frame is captured on the bin-3 beat with no bubble.
- Reset mid-operation: assert rst_n after 2 input beats and during drain → m_valid=0, s_ready=1, frame_cnt=0. The next clean impulse frame produces the correct bins.
- Throughput/wrap: 2^FCW+3 back-to-back frames with FCW=4, m_ready=1 → no lost or duplicated bins, frame_cnt wraps 15→0, exactly one m_last per frame.
